// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache.
// Sits between the MEM stage load/store port and a multi-cycle req/ack
// data memory. Each line holds one word (valid bit, tag, data).
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   cpu_req/cpu_we  load/store request from MEM stage (held while stalled)
//   addr_mode       0 = word access, 1 = byte access
//   cpu_addr        byte address; cpu_wdata store data (byte mode: [7:0])
//   cpu_rdata       load data, combinational on a hit
//   cpu_stall       hold the pipeline; access not yet complete
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be   registered memory request
//   mem_ack/mem_rdata                          one-cycle completion + data
//
// Optional build macro DCACHE_STATS_EN adds saturating hit_count and
// miss_count outputs (one count per completed CPU access).
module data_cache #(
    parameter int WIDTH = 32,
    parameter int SETS  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic             addr_mode,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             cpu_stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count
`endif
);

    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = WIDTH - 2 - IDXW;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_MISS = 2'd1;
    localparam logic [1:0] WR_THRU = 2'd2;

    logic [1:0]       state;
    // Set for the single cycle after a memory ack: the still-presented
    // request is the one just serviced and must not start a new transaction.
    logic             done;
    logic [SETS-1:0]  valid;
    logic [TAGW-1:0]  tags [SETS];
    logic [WIDTH-1:0] data [SETS];

    logic [1:0]       offset;
    logic [IDXW-1:0]  index;
    logic [TAGW-1:0]  tag;
    logic [IDXW-1:0]  fill_index;
    logic [TAGW-1:0]  fill_tag;
    logic [WIDTH-1:0] line;
    logic             hit;
    logic             idle_req;
    logic             start_rd;
    logic             start_wr;
    logic [3:0]       st_be;
    logic [WIDTH-1:0] st_wdata;
    logic [WIDTH-1:0] st_merged;

    assign offset     = cpu_addr[1:0];
    assign index      = cpu_addr[2 +: IDXW];
    assign tag        = cpu_addr[WIDTH-1 -: TAGW];
    // Refill location comes from the latched memory address, not the CPU port.
    assign fill_index = mem_addr[2 +: IDXW];
    assign fill_tag   = mem_addr[WIDTH-1 -: TAGW];
    assign line       = data[index];
    assign hit        = valid[index] && (tags[index] == tag);

    assign idle_req  = (state == IDLE) && cpu_req && !done;
    assign start_rd  = idle_req && !cpu_we && !hit;
    assign start_wr  = idle_req && cpu_we;
    assign cpu_stall = rst && ((state != IDLE) || start_rd || start_wr);

    always_comb begin
        st_be     = addr_mode ? (4'b0001 << offset) : 4'hF;
        st_wdata  = addr_mode ? {(WIDTH/8){cpu_wdata[7:0]}} : cpu_wdata;
        st_merged = line;
        for (int unsigned i = 0; i < 4; i++) begin
            if (st_be[i]) begin
                st_merged[i*8 +: 8] = st_wdata[i*8 +: 8];
            end
        end
    end

    always_comb begin
        cpu_rdata = '0;
        if ((state == IDLE) && cpu_req && !cpu_we && hit) begin
            if (addr_mode) begin
                cpu_rdata = {{(WIDTH-8){1'b0}}, line[{offset, 3'b000} +: 8]};
            end else begin
                cpu_rdata = line;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            done      <= 1'b0;
            valid     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            for (int unsigned i = 0; i < SETS; i++) begin
                tags[i] <= '0;
                data[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_rd) begin
                        state    <= RD_MISS;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {cpu_addr[WIDTH-1:2], 2'b00};
                        mem_be   <= 4'hF;
                    end else if (start_wr) begin
                        state     <= WR_THRU;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {cpu_addr[WIDTH-1:2], 2'b00};
                        mem_be    <= st_be;
                        mem_wdata <= st_wdata;
                        if (hit) begin
                            data[index] <= st_merged;
                        end
                    end
                end
                RD_MISS: begin
                    if (mem_ack) begin
                        valid[fill_index] <= 1'b1;
                        tags[fill_index]  <= fill_tag;
                        data[fill_index]  <= mem_rdata;
                        mem_req           <= 1'b0;
                        mem_be            <= '0;
                        state             <= IDLE;
                        done              <= 1'b1;
                    end
                end
                WR_THRU: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= '0;
                        state   <= IDLE;
                        done    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            // A refill's follow-up hit cycle has done=1 and is not a new hit.
            if ((state == IDLE) && cpu_req && !cpu_we && hit && !done &&
                (hit_count != '1)) begin
                hit_count <= hit_count + 32'd1;
            end
            if ((state != IDLE) && mem_ack && (miss_count != '1)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
